// File: rtl/timing_control.sv
// Carrier-locked timebase: counts carrier pulses into seconds and minutes and
// raises BRAM write strobes. Optional macro TIMING_CONTROL_FREQ_CLAMP_EN.
module timing_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        msf_carrier_pulse,
  input  logic [16:0] msf_frequency,
  input  logic [16:0] low_time,
  output logic [16:0] msf_carrier_counter,
  output logic        one_sec_marker,
  output logic [5:0]  second_counter,
  output logic [3:0]  write_second_bram,
  output logic [3:0]  write_minute_bram
);

  logic [16:0] cnt_q, cnt_d;
  logic        mark_q, mark_d;
  logic [5:0]  sec_q, sec_d;
  logic [3:0]  wsec_q, wsec_d;
  logic [3:0]  wmin_q, wmin_d;
  logic [16:0] termVal;
  logic        freqValid;
  logic        terminal;

  // A zero frequency has no terminal value, so it must never be compared against.
  always_comb begin
    termVal   = msf_frequency - 17'd1;
    freqValid = |msf_frequency;
`ifdef TIMING_CONTROL_FREQ_CLAMP_EN
    terminal  = freqValid && (cnt_q >= termVal);
`else
    terminal  = freqValid && (cnt_q == termVal);
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    sec_d  = sec_q;
    mark_d = 1'b0;
    wsec_d = 4'h0;
    wmin_d = 4'h0;
    if (msf_carrier_pulse) begin
      if (!freqValid) begin
        cnt_d = 17'd0;
      end else if (terminal) begin
        cnt_d  = 17'd0;
        mark_d = 1'b1;
        if (sec_q == 6'd59) begin
          sec_d  = 6'd0;
          wmin_d = 4'hF;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        cnt_d = cnt_q + 17'd1;
      end
      // A zero capture point only counts at a real boundary, not the natural 2^17 wrap.
      if (freqValid && (low_time < msf_frequency) && (cnt_d == low_time) &&
          (terminal || (low_time != 17'd0))) begin
        wsec_d = 4'hF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 17'd0;
      sec_q  <= 6'd0;
      mark_q <= 1'b0;
      wsec_q <= 4'h0;
      wmin_q <= 4'h0;
    end else begin
      cnt_q  <= cnt_d;
      sec_q  <= sec_d;
      mark_q <= mark_d;
      wsec_q <= wsec_d;
      wmin_q <= wmin_d;
    end
  end

  assign msf_carrier_counter = cnt_q;
  assign one_sec_marker      = mark_q;
  assign second_counter      = sec_q;
  assign write_second_bram   = wsec_q;
  assign write_minute_bram   = wmin_q;

endmodule

// File: tb/tb_timing_control.sv
// Directed-vector bench for timing_control; expectations are hand-derived,
// and the clamp sequence follows TIMING_CONTROL_FREQ_CLAMP_EN.
module tb_timing_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        pulse;
  logic [16:0] freq;
  logic [16:0] low;
  logic [16:0] cnt;
  logic        mark;
  logic [5:0]  sec;
  logic [3:0]  wsec;
  logic [3:0]  wmin;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        r;
    logic        p;
    logic [16:0] f;
    logic [16:0] l;
    logic [16:0] c;
    logic        m;
    logic [5:0]  s;
    logic [3:0]  ws;
    logic [3:0]  wm;
  } vec_t;

  vec_t vecs[$];

  timing_control dut (
    .clk                 (clk),
    .rst                 (rst),
    .msf_carrier_pulse   (pulse),
    .msf_frequency       (freq),
    .low_time            (low),
    .msf_carrier_counter (cnt),
    .one_sec_marker      (mark),
    .second_counter      (sec),
    .write_second_bram   (wsec),
    .write_minute_bram   (wmin)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic p, input int f, input int l,
                        input int c, input logic m, input int s, input logic ws, input logic wm);
    vec_t v;
    v.r = r; v.p = p; v.f = 17'(f); v.l = 17'(l); v.c = 17'(c); v.m = m; v.s = 6'(s);
    v.ws = ws ? 4'hF : 4'h0;
    v.wm = wm ? 4'hF : 4'h0;
    vecs.push_back(v);
  endtask

  // Inputs change 1 time unit after the edge, so outputs are sampled well away from it.
  task automatic applyStimulus(input logic r, input logic p, input int f, input int l);
    rst = r; pulse = p; freq = 17'(f); low = 17'(l);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int c, input logic m, input int s,
                             input logic [3:0] ws, input logic [3:0] wm);
    total++;
    if (cnt !== 17'(c) || mark !== m || sec !== 6'(s) || wsec !== ws || wmin !== wm) begin
      bad++;
      $display("[TB] FAIL %s: got cnt=%0d mark=%0b sec=%0d wsec=%h wmin=%h, want cnt=%0d mark=%0b sec=%0d wsec=%h wmin=%h",
               name, cnt, mark, sec, wsec, wmin, c, m, s, ws, wm);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int k, s, markers, firstMark, lastMark, minuteHits;
    rst = 1'b1; pulse = 1'b0; freq = 17'd10; low = 17'd3;

    // Reset held with pulses active, then basic counting and capture strobe at 3
    for (int i = 0; i < 5; i++) addVec(1, 1, 10, 3, 0, 0, 0, 0, 0);
    addVec(0, 1, 10, 3, 1, 0, 0, 0, 0);
    addVec(0, 0, 10, 3, 1, 0, 0, 0, 0);
    addVec(0, 1, 10, 3, 2, 0, 0, 0, 0);
    addVec(0, 1, 10, 3, 3, 0, 0, 1, 0);
    addVec(0, 0, 10, 3, 3, 0, 0, 0, 0);
    for (int c = 4; c <= 9; c++) addVec(0, 1, 10, 3, c, 0, 0, 0, 0);
    addVec(0, 1, 10, 3, 0, 1, 1, 0, 0);
    addVec(0, 0, 10, 3, 0, 0, 1, 0, 0);
    for (int c = 1; c <= 7; c++) addVec(0, 1, 10, 3, c, 0, 1, c == 3, 0);
    // Reset mid-second at count 7 discards everything, no marker
    addVec(1, 1, 10, 3, 0, 0, 0, 0, 0);
    addVec(0, 0, 10, 3, 0, 0, 0, 0, 0);
    // low_time = 0 fires with the marker only
    for (int c = 1; c <= 9; c++) addVec(0, 1, 10, 0, c, 0, 0, 0, 0);
    addVec(0, 1, 10, 0, 0, 1, 1, 1, 0);
    addVec(0, 1, 10, 0, 1, 0, 1, 0, 0);
    // freq = 1: every pulse is a boundary; then freq = 0 holds silently
    addVec(1, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 0, 1, 1, 1, 0);
    addVec(0, 1, 1, 0, 0, 1, 2, 1, 0);
    addVec(0, 0, 1, 0, 0, 0, 2, 0, 0);
    addVec(0, 1, 0, 0, 0, 0, 2, 0, 0);
    addVec(0, 1, 0, 0, 0, 0, 2, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].p, vecs[i].f, vecs[i].l);
      checkOutput($sformatf("vec%0d", i), vecs[i].c, vecs[i].m, vecs[i].s, vecs[i].ws, vecs[i].wm);
    end

    // Sparse pulses every 165 clks, low_time 12 never captures
    applyStimulus(1, 0, 10, 12);
    k = 0; markers = 0; firstMark = 0; lastMark = 0;
    for (int i = 1; i <= 3300; i++) begin
      applyStimulus(0, (i % 165) == 0, 10, 12);
      if ((i % 165) == 0) k++;
      checkOutput("sparse", k % 10, ((i % 165) == 0) && (k % 10 == 0), k / 10, 4'h0, 4'h0);
      if (mark === 1'b1) begin
        markers++;
        if (markers == 1) firstMark = i;
        lastMark = i;
      end
    end
    checkCount("sparse_markers", markers, 2);
    checkCount("sparse_period", lastMark - firstMark, 1650);

    // 61 seconds back-to-back: minute strobe exactly once, on the 59->0 marker
    applyStimulus(1, 0, 10, 3);
    minuteHits = 0;
    for (s = 1; s <= 61; s++) begin
      for (int p = 1; p <= 10; p++) begin
        applyStimulus(0, 1, 10, 3);
        checkOutput("minute", p % 10, p == 10, (p == 10) ? (s % 60) : ((s - 1) % 60),
                    (p == 3) ? 4'hF : 4'h0, (p == 10 && s == 60) ? 4'hF : 4'h0);
        if (wmin === 4'hF) minuteHits++;
      end
    end
    checkCount("minute_hits", minuteHits, 1);

    // Nominal frequency: capture exactly at count 303
    applyStimulus(1, 0, 77500, 303);
    for (int i = 1; i <= 305; i++) begin
      applyStimulus(0, 1, 77500, 303);
      checkOutput("nominal", i, 1'b0, 0, (i == 303) ? 4'hF : 4'h0, 4'h0);
    end

    // Lowering the frequency below the current count
    applyStimulus(1, 0, 10, 3);
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1, 10, 3);
    checkOutput("pre_lower", 7, 1'b0, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 5, 3);
`ifdef TIMING_CONTROL_FREQ_CLAMP_EN
    checkOutput("lower_1", 0, 1'b1, 1, 4'h0, 4'h0);
    applyStimulus(0, 1, 5, 3);
    checkOutput("lower_2", 1, 1'b0, 1, 4'h0, 4'h0);
`else
    checkOutput("lower_1", 8, 1'b0, 0, 4'h0, 4'h0);
    applyStimulus(0, 1, 5, 3);
    checkOutput("lower_2", 9, 1'b0, 0, 4'h0, 4'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
